// File: rtl/iq_pkg.sv
// Shared definitions for the instruction queue and decode: field widths, NOP opcode, width helpers.
// Optional parity support in the queue is enabled by defining IQ_PARITY_EN.
package iq_pkg;

    localparam int IQ_INSTR_W   = 32;
    localparam int IQ_OPCODE_W  = 4;
    localparam int IQ_OPERAND_W = IQ_INSTR_W - IQ_OPCODE_W;
    localparam int IQ_OPCODE_LSB = IQ_INSTR_W - IQ_OPCODE_W;

    localparam logic [IQ_OPCODE_W-1:0] OPCODE_NOP = '1;

    function automatic int iq_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int iq_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/iq_ptr.sv
// Modulo-DEPTH pointer with increment and synchronous clear; clear wins over increment.
// Latency: one cycle from i_inc/i_clr to o_ptr. No backpressure of its own.
module iq_ptr
    import iq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_clr,
    input  logic                        i_inc,
    output logic [iq_ptr_w(DEPTH)-1:0]  o_ptr
);

    localparam int PTR_W = iq_ptr_w(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] r_ptr;

    // Explicit wrap so non-power-of-two depths work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/instr_queue_reg.sv
// DEPTH-entry show-ahead instruction queue between fetch and decode; head split into opcode/operand.
// Latency 1 cycle push-to-head; in_ready drops at count==DEPTH; flush clears. IQ_PARITY_EN adds parity.
module instr_queue_reg
    import iq_pkg::*;
#(
    parameter int INSTR_W  = 32,
    parameter int OPCODE_W = 4,
    parameter int DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INSTR_W-1:0]            in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OPCODE_W-1:0]           out_opcode,
    output logic [INSTR_W-OPCODE_W-1:0]   out_operand,
    output logic [iq_cnt_w(DEPTH)-1:0]    count
`ifdef IQ_PARITY_EN
    ,
    input  logic                          in_parity,
    output logic                          out_par_err
`endif
);

    localparam int CNT_W     = iq_cnt_w(DEPTH);
    localparam int PTR_W     = iq_ptr_w(DEPTH);
    localparam int OPERAND_W = INSTR_W - OPCODE_W;

    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   w_wr_ptr;
    logic [PTR_W-1:0]   w_rd_ptr;
    logic               w_push;
    logic               w_pop;
    logic [INSTR_W-1:0] w_head;

    assign in_ready  = (r_count < CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;
    assign count     = r_count;
    assign w_head    = r_mem[w_rd_ptr];

    iq_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (flush),
        .i_inc (w_push),
        .o_ptr (w_wr_ptr)
    );

    iq_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (flush),
        .i_inc (w_pop),
        .o_ptr (w_rd_ptr)
    );

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Empty queue presents a NOP rather than whatever sits in storage.
    always_comb begin
        out_opcode  = '1;
        out_operand = '0;
        if (out_valid) begin
            out_opcode  = w_head[INSTR_W-1 -: OPCODE_W];
            out_operand = w_head[OPERAND_W-1:0];
        end
    end

`ifdef IQ_PARITY_EN
    logic r_par [DEPTH];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_par[w_wr_ptr] <= in_parity;
        end
    end

    assign out_par_err = out_valid & (^{w_head, r_par[w_rd_ptr]});
`endif

endmodule

// File: tb/tb_instr_queue_reg.sv
// Directed bench for instr_queue_reg (DEPTH=4); parity steps are compiled in when IQ_PARITY_EN is defined.
module tb_instr_queue_reg;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [27:0] out_operand;
    logic [2:0]  count;
`ifdef IQ_PARITY_EN
    logic        in_parity;
    logic        out_par_err;
    logic        par_force;
    logic        par_val;
    assign in_parity = par_force ? par_val : ^in_data;
`endif

    int checks;
    int failures;
    logic [31:0] words [1:9];

    instr_queue_reg #(.INSTR_W(32), .OPCODE_W(4), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_operand (out_operand),
        .count       (count)
`ifdef IQ_PARITY_EN
        ,
        .in_parity   (in_parity),
        .out_par_err (out_par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] word);
        chk({tag, "_valid"},   {31'd0, out_valid}, 32'd1);
        chk({tag, "_opcode"},  {28'd0, out_opcode}, {28'd0, word[31:28]});
        chk({tag, "_operand"}, {4'd0, out_operand}, {4'd0, word[27:0]});
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"},   {31'd0, out_valid}, 32'd0);
        chk({tag, "_opcode"},  {28'd0, out_opcode}, 32'hF);
        chk({tag, "_operand"}, {4'd0, out_operand}, 32'd0);
        chk({tag, "_count"},   {29'd0, count}, 32'd0);
        chk({tag, "_ready"},   {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 1; i <= 9; i++) begin
            words[i] = {i[3:0], 28'h00000A0 + 28'(i)};
        end
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef IQ_PARITY_EN
        par_force = 1'b0; par_val = 1'b0;
`endif
        #1;
        chk_empty("reset");
        #11 rst_n = 1'b1;

        // Single push into empty queue, then pop it.
        in_valid = 1'b1; in_data = 32'h1234_5678;
        tick();
        in_valid = 1'b0;
        chk_head("push1", 32'h1234_5678);
        chk("push1_count", {29'd0, count}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_empty("pop1");

        // Fill to DEPTH, hold a word against a full queue, then drain in order.
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = words[i];
            tick();
        end
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        in_data = 32'hE000_000E;
        tick();
        chk("full_hold_count", {29'd0, count}, 32'd4);
        chk_head("full_hold_head", words[1]);
        out_ready = 1'b1;
        tick();
        chk("full_poppush_count", {29'd0, count}, 32'd3);
        in_valid = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            chk_head("drain_head", words[i]);
            tick();
        end
        out_ready = 1'b0;
        chk_empty("drained");

        // Steady state at count=2 with simultaneous push and pop across wrap.
        in_valid = 1'b1;
        in_data = words[1]; tick();
        in_data = words[2]; tick();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data = words[k + 3];
            chk_head("stream_head", words[k + 1]);
            tick();
            chk("stream_count", {29'd0, count}, 32'd2);
        end
        out_ready = 1'b0;
        chk_head("stream_end_head", words[7]);

        // Flush at count=3 overrides same-cycle push and pop.
        in_data = words[9]; tick();
        chk("preflush_count", {29'd0, count}, 32'd3);
        flush = 1'b1; out_ready = 1'b1; in_data = 32'h5555_AAAA;
        tick();
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        chk_empty("flush");
        in_valid = 1'b1; in_data = 32'h6000_0006;
        tick();
        chk_head("postflush_head", 32'h6000_0006);
        chk("postflush_count", {29'd0, count}, 32'd1);

        // Asynchronous reset in the middle of traffic.
        in_data = 32'h7000_0007;
        tick();
        chk("prereset_count", {29'd0, count}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk_empty("async_reset");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef IQ_PARITY_EN
        par_force = 1'b1;
        par_val   = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_0001;
        tick();
        in_valid = 1'b0;
        chk("par_bad", {31'd0, out_par_err}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("par_empty", {31'd0, out_par_err}, 32'd0);
        chk("par_popped_count", {29'd0, count}, 32'd0);
        par_val  = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("par_good", {31'd0, out_par_err}, 32'd0);
        chk_head("par_good_head", 32'h0000_0001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
